// File: rtl/call_stack_pc_pkg.sv
// Shared defaults and FSM encoding for the call/return program counter.
package call_stack_pc_pkg;

    localparam int unsigned ADDR_W_DEF       = 10;
    localparam int unsigned DEPTH_DEF        = 8;
    localparam logic [9:0]  RESET_VECTOR_DEF = 10'h000;
    localparam int unsigned DEPTH_W          = 4;
    localparam int unsigned JUMP_W           = 10;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO; an entry count tracks occupancy so contents need no reset.
module lifo_stack #(
    parameter int unsigned Width  = 10,
    parameter int unsigned Depth  = 8,
    parameter int unsigned DepthW = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [Width-1:0]  data_in_i,
    output logic [Width-1:0]  data_out_o,
    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [DepthW-1:0] depth_q, depth_d;
    logic [IdxW-1:0]   wr_idx, rd_idx;
    logic              do_push, do_pop;

    assign full_o     = (depth_q == DepthW'(Depth));
    assign empty_o    = (depth_q == '0);
    assign depth_o    = depth_q;
    assign wr_idx     = IdxW'(depth_q);
    assign rd_idx     = IdxW'(depth_q - DepthW'(1));
    assign data_out_o = mem_q[rd_idx];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o && !push_i;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DepthW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DepthW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_idx] <= data_in_i;
        end
    end

endmodule

// File: rtl/call_stack_pc.sv
// Program counter with BSR/RET handling, a hardware return stack and sticky error flags.
module call_stack_pc
    import call_stack_pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = ADDR_W_DEF,
    parameter int unsigned       DEPTH        = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               HOLD,
    input  logic               bsr_det,
    input  logic               ret_det,
    input  logic [JUMP_W-1:0]  relative_jump,
    output logic [ADDR_W-1:0]  PC,
    output logic               flush,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_overflow,
    output logic               stack_underflow,
    output logic               conflict
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              conf_q, conf_d;

    logic [ADDR_W-1:0] jump_ext, pc_inc, stk_top;
    logic              stk_push, stk_pop, stk_full, stk_empty;

    assign jump_ext = ADDR_W'($signed(relative_jump));
    assign pc_inc   = pc_q + ADDR_W'(1);

    lifo_stack #(
        .Width  (ADDR_W),
        .Depth  (DEPTH),
        .DepthW (DEPTH_W)
    ) u_stack (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .push_i     (stk_push),
        .pop_i      (stk_pop),
        .data_in_i  (pc_inc),
        .data_out_o (stk_top),
        .depth_o    (depth),
        .full_o     (stk_full),
        .empty_o    (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        conf_d   = conf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (!HOLD) begin
            pc_d = pc_inc;
            case (state_q)
                StRun: begin
                    if (bsr_det && ret_det) begin
                        conf_d = 1'b1;
                    end else if (bsr_det) begin
                        // Jump is taken even when the return address cannot be saved.
                        pc_d    = pc_q + jump_ext;
                        state_d = StFlush;
                        if (stk_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                        end
                    end else if (ret_det) begin
                        if (stk_empty) begin
                            unf_d = 1'b1;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                            state_d = StFlush;
                        end
                    end
                end
                StFlush: state_d = StRun;
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StRun;
            pc_q    <= RESET_VECTOR;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            conf_q  <= conf_d;
        end
    end

    assign PC              = pc_q;
    assign flush           = (state_q == StFlush) && !HOLD;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
    assign conflict        = conf_q;

endmodule

// File: tb/tb_call_stack_pc.sv
// Directed bench for call_stack_pc: reset, BSR/RET, stack limits, wrap, conflict, HOLD.
module tb_call_stack_pc;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       HOLD = 1'b0;
    logic       bsr_det = 1'b0;
    logic       ret_det = 1'b0;
    logic [9:0] relative_jump = '0;
    logic [9:0] PC;
    logic       flush;
    logic [3:0] depth;
    logic       stack_overflow, stack_underflow, conflict;

    int checks = 0;
    int failures = 0;

    call_stack_pc dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .HOLD            (HOLD),
        .bsr_det         (bsr_det),
        .ret_det         (ret_det),
        .relative_jump   (relative_jump),
        .PC              (PC),
        .flush           (flush),
        .depth           (depth),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow),
        .conflict        (conflict)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        bsr_det = 1'b0; ret_det = 1'b0; HOLD = 1'b0; relative_jump = '0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        HOLD = 1'b1;
        RESET = 1'b1;
        tick();
        tick();
        checks++; if (PC !== 10'h000) begin failures++; $display("FAIL reset_pc: got %h want 000", PC); end
        checks++; if (depth !== 4'd0) begin failures++; $display("FAIL reset_depth: got %0d want 0", depth); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++;
        if ({stack_overflow, stack_underflow, conflict} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000", {stack_overflow, stack_underflow, conflict});
        end
        HOLD = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic test_idle();
        logic [9:0] exp_pc;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 10'(i);
            checks++; if (PC !== exp_pc) begin failures++; $display("FAIL idle_pc%0d: got %h want %h", i, PC, exp_pc); end
            checks++; if (flush !== 1'b0 || depth !== 4'd0) begin
                failures++; $display("FAIL idle_state%0d: got flush=%b depth=%0d want 0/0", i, flush, depth);
            end
        end
    endtask

    task automatic test_bsr_ret();
        do_reset();
        repeat (16) tick();
        checks++; if (PC !== 10'h010) begin failures++; $display("FAIL br_start: got %h want 010", PC); end
        bsr_det = 1'b1; relative_jump = 10'h020;
        tick();
        bsr_det = 1'b0;
        checks++; if (PC !== 10'h030) begin failures++; $display("FAIL bsr_pc: got %h want 030", PC); end
        checks++; if (depth !== 4'd1) begin failures++; $display("FAIL bsr_depth: got %0d want 1", depth); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL bsr_flush: got %b want 1", flush); end
        tick();
        checks++; if (PC !== 10'h031 || flush !== 1'b0) begin
            failures++; $display("FAIL bsr_after: got pc=%h flush=%b want 031/0", PC, flush);
        end
        ret_det = 1'b1;
        tick();
        ret_det = 1'b0;
        checks++; if (PC !== 10'h011) begin failures++; $display("FAIL ret_pc: got %h want 011", PC); end
        checks++; if (depth !== 4'd0 || flush !== 1'b1) begin
            failures++; $display("FAIL ret_state: got depth=%0d flush=%b want 0/1", depth, flush);
        end
        tick();
        checks++; if (PC !== 10'h012 || flush !== 1'b0) begin
            failures++; $display("FAIL ret_after: got pc=%h flush=%b want 012/0", PC, flush);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [9:0] exp_pc;
        logic [3:0] exp_depth;
        do_reset();
        relative_jump = 10'h010;
        // Before BSR k the PC is 0x11*k, so the saved return address is 0x11*k+1.
        for (int k = 0; k < 9; k++) begin
            bsr_det = 1'b1;
            tick();
            bsr_det = 1'b0;
            exp_pc = 10'(17 * k + 16);
            exp_depth = (k < 8) ? 4'(k + 1) : 4'd8;
            checks++; if (PC !== exp_pc || depth !== exp_depth || flush !== 1'b1) begin
                failures++;
                $display("FAIL bsr%0d: got pc=%h depth=%0d flush=%b want %h/%0d/1", k, PC, depth, flush,
                         exp_pc, exp_depth);
            end
            checks++; if (stack_overflow !== (k == 8)) begin
                failures++; $display("FAIL ovf%0d: got %b want %b", k, stack_overflow, k == 8);
            end
            tick();
        end
        checks++; if (PC !== 10'h099) begin failures++; $display("FAIL ovf_end_pc: got %h want 099", PC); end
        for (int j = 0; j < 8; j++) begin
            ret_det = 1'b1;
            tick();
            ret_det = 1'b0;
            exp_pc = 10'(17 * (7 - j) + 1);
            exp_depth = 4'(7 - j);
            checks++; if (PC !== exp_pc || depth !== exp_depth || flush !== 1'b1) begin
                failures++;
                $display("FAIL ret%0d: got pc=%h depth=%0d flush=%b want %h/%0d/1", j, PC, depth, flush,
                         exp_pc, exp_depth);
            end
            tick();
        end
        checks++; if (stack_underflow !== 1'b0) begin failures++; $display("FAIL unf_early: got %b want 0", stack_underflow); end
        ret_det = 1'b1;
        tick();
        ret_det = 1'b0;
        checks++; if (stack_underflow !== 1'b1) begin failures++; $display("FAIL unf_set: got %b want 1", stack_underflow); end
        checks++; if (PC !== 10'h003 || flush !== 1'b0 || depth !== 4'd0) begin
            failures++; $display("FAIL unf_state: got pc=%h flush=%b depth=%0d want 003/0/0", PC, flush, depth);
        end
        tick();
        checks++; if (stack_overflow !== 1'b1 || stack_underflow !== 1'b1) begin
            failures++; $display("FAIL sticky: got ovf=%b unf=%b want 1/1", stack_overflow, stack_underflow);
        end
        #1 RESET = 1'b1;
        #1;
        checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
            failures++; $display("FAIL sticky_clr: got ovf=%b unf=%b want 0/0", stack_overflow, stack_underflow);
        end
        RESET = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        tick();
        bsr_det = 1'b1; relative_jump = 10'h3FC;
        tick();
        bsr_det = 1'b0;
        checks++; if (PC !== 10'h3FE) begin failures++; $display("FAIL wrap_neg: got %h want 3fe", PC); end
        tick();
        checks++; if (PC !== 10'h3FF) begin failures++; $display("FAIL wrap_3ff: got %h want 3ff", PC); end
        tick();
        checks++; if (PC !== 10'h000) begin failures++; $display("FAIL wrap_zero: got %h want 000", PC); end
    endtask

    task automatic test_conflict();
        do_reset();
        bsr_det = 1'b1; ret_det = 1'b1; relative_jump = 10'h020;
        tick();
        ret_det = 1'b0;
        bsr_det = 1'b0;
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL conf_set: got %b want 1", conflict); end
        checks++; if (PC !== 10'h001 || depth !== 4'd0 || flush !== 1'b0) begin
            failures++; $display("FAIL conf_state: got pc=%h depth=%0d flush=%b want 001/0/0", PC, depth, flush);
        end
        bsr_det = 1'b1;
        tick();
        checks++; if (PC !== 10'h021 || flush !== 1'b1) begin
            failures++; $display("FAIL conf_bsr: got pc=%h flush=%b want 021/1", PC, flush);
        end
        relative_jump = 10'h100;
        tick();
        bsr_det = 1'b0;
        checks++; if (PC !== 10'h022 || depth !== 4'd1 || flush !== 1'b0) begin
            failures++; $display("FAIL flush_ignore: got pc=%h depth=%0d flush=%b want 022/1/0", PC, depth, flush);
        end
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL conf_sticky: got %b want 1", conflict); end
    endtask

    task automatic test_hold();
        do_reset();
        bsr_det = 1'b1; relative_jump = 10'h040;
        tick();
        bsr_det = 1'b0;
        checks++; if (PC !== 10'h040 || flush !== 1'b1) begin
            failures++; $display("FAIL hold_bsr: got pc=%h flush=%b want 040/1", PC, flush);
        end
        HOLD = 1'b1;
        ret_det = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (PC !== 10'h040 || flush !== 1'b0 || depth !== 4'd1) begin
                failures++;
                $display("FAIL hold%0d: got pc=%h flush=%b depth=%0d want 040/0/1", i, PC, flush, depth);
            end
        end
        ret_det = 1'b0;
        HOLD = 1'b0;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL hold_release: got %b want 1", flush); end
        tick();
        checks++; if (PC !== 10'h041 || flush !== 1'b0 || depth !== 4'd1) begin
            failures++; $display("FAIL hold_done: got pc=%h flush=%b depth=%0d want 041/0/1", PC, flush, depth);
        end
        bsr_det = 1'b1;
        tick();
        bsr_det = 1'b0;
        // Asynchronous reset between edges, in the middle of a FLUSH.
        #1 RESET = 1'b1;
        #1;
        checks++; if (PC !== 10'h000 || flush !== 1'b0 || depth !== 4'd0) begin
            failures++; $display("FAIL async_rst: got pc=%h flush=%b depth=%0d want 000/0/0", PC, flush, depth);
        end
        RESET = 1'b0;
        tick();
        checks++; if (PC !== 10'h001 || flush !== 1'b0) begin
            failures++; $display("FAIL post_rst: got pc=%h flush=%b want 001/0", PC, flush);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_bsr_ret();
        test_overflow_underflow();
        test_wrap();
        test_conflict();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
